// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C transaction sequencer: byte-engine opcodes,
// completion status codes and the sequencer state enumeration.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_ADDR_NACK = 2'd1,
    ERR_DATA_NACK = 2'd2,
    ERR_ABORT     = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADDR_W = 4'd2,
    S_REG    = 4'd3,
    S_WDATA  = 4'd4,
    S_RSTART = 4'd5,
    S_ADDR_R = 4'd6,
    S_RDATA  = 4'd7,
    S_STOP   = 4'd8,
    S_DONE   = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_txn_ctrl_if.sv
// Bundle of request, write-stream, read-return and byte-engine signals of the
// transaction sequencer; master = requester/engine side, slave = sequencer.
interface i2c_txn_ctrl_if #(
  parameter int LEN_W = 4
) ();

  // Handshakes: a transfer happens on a cycle where valid && ready are both high.
  // A valid, once raised, holds its payload stable until that cycle. rd_valid,
  // done and rsp_valid are one-cycle pulses with no backpressure.
  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [LEN_W-1:0] req_len;
  logic             abort;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             done;
  logic [1:0]       err;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_wdata;
  logic             cmd_nack;
  logic             rsp_valid;
  logic             rsp_nack;
  logic [7:0]       rsp_rdata;

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_len, abort,
    output wr_valid, wr_data, cmd_ready, rsp_valid, rsp_nack, rsp_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, done, err,
    input  cmd_valid, cmd_op, cmd_wdata, cmd_nack
  );

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_len, abort,
    input  wr_valid, wr_data, cmd_ready, rsp_valid, rsp_nack, rsp_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, done, err,
    output cmd_valid, cmd_op, cmd_wdata, cmd_nack
  );

endinterface

// File: rtl/i2c_txn_ctrl.sv
// Register-oriented I2C transaction sequencer: turns one read/write request
// into the START/WRITE/READ/STOP byte-command stream and reports status.
module i2c_txn_ctrl
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  i2c_txn_ctrl_if.slave bus,
  output state_e        dbg_state_o
);

  state_e           state_q, state_d;
  logic             wait_q;
  logic             rw_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  err_e             err_acc_q, err_d;
  logic             req_ready_q;
  logic             cmd_valid_q, issue_d;
  cmd_op_e          cmd_op_q, op_d;
  logic [7:0]       cmd_wdata_q, wdata_d;
  logic             cmd_nack_q, nack_d;
  logic             rd_valid_q;
  logic [7:0]       rd_data_q;
  logic             done_q;
  logic [1:0]       err_q;

  // Successor of a wait phase, applied when rsp_valid arrives. Any NACK or abort
  // falls through to the STOP defaults; NACK is tested first so it wins.
  always_comb begin
    state_d = S_STOP;
    op_d    = OP_STOP;
    wdata_d = cmd_wdata_q;
    nack_d  = 1'b0;
    err_d   = err_acc_q;
    cnt_d   = cnt_q;
    issue_d = 1'b1;
    case (state_q)
      S_START: begin
        if (bus.abort) err_d = ERR_ABORT;
        else begin state_d = S_ADDR_W; op_d = OP_WRITE; wdata_d = {dev_q, 1'b0}; end
      end
      S_ADDR_W: begin
        if (bus.rsp_nack)   err_d = ERR_ADDR_NACK;
        else if (bus.abort) err_d = ERR_ABORT;
        else begin state_d = S_REG; op_d = OP_WRITE; wdata_d = reg_q; end
      end
      S_REG: begin
        if (bus.rsp_nack)        err_d = ERR_DATA_NACK;
        else if (bus.abort)      err_d = ERR_ABORT;
        else if (cnt_q == '0)    state_d = S_STOP;
        else if (rw_q)           begin state_d = S_RSTART; op_d = OP_START; end
        else                     begin state_d = S_WDATA; op_d = OP_WRITE; issue_d = 1'b0; end
      end
      S_WDATA: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (bus.rsp_nack)     err_d = ERR_DATA_NACK;
        else if (bus.abort)   err_d = ERR_ABORT;
        else if (cnt_d != '0) begin state_d = S_WDATA; op_d = OP_WRITE; issue_d = 1'b0; end
      end
      S_RSTART: begin
        if (bus.abort) err_d = ERR_ABORT;
        else begin state_d = S_ADDR_R; op_d = OP_WRITE; wdata_d = {dev_q, 1'b1}; end
      end
      S_ADDR_R: begin
        if (bus.rsp_nack)   err_d = ERR_ADDR_NACK;
        else if (bus.abort) err_d = ERR_ABORT;
        else begin state_d = S_RDATA; op_d = OP_READ; nack_d = (cnt_q == LEN_W'(1)); end
      end
      S_RDATA: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (bus.abort)        err_d = ERR_ABORT;
        else if (cnt_d != '0) begin state_d = S_RDATA; op_d = OP_READ; nack_d = (cnt_d == LEN_W'(1)); end
      end
      S_STOP:  begin state_d = S_DONE; issue_d = 1'b0; end
      default: begin state_d = S_IDLE; issue_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      err_acc_q   <= ERR_OK;
      req_ready_q <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_START;
      cmd_wdata_q <= '0;
      cmd_nack_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            rw_q        <= bus.req_rw;
            dev_q       <= bus.req_dev;
            reg_q       <= bus.req_reg;
            cnt_q       <= bus.req_len;
            err_acc_q   <= ERR_OK;
            req_ready_q <= 1'b0;
            state_q     <= S_START;
            wait_q      <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_START;
            cmd_nack_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          if (!wait_q) begin
            if (cmd_valid_q) begin
              if (bus.cmd_ready) begin
                cmd_valid_q <= 1'b0;
                wait_q      <= 1'b1;
              end
            end else if (state_q == S_WDATA) begin
              // Data byte is captured here and consumed from the stream at the cmd handshake.
              if (bus.wr_valid) begin
                cmd_valid_q <= 1'b1;
                cmd_wdata_q <= bus.wr_data;
              end else if (bus.abort) begin
                err_acc_q   <= ERR_ABORT;
                state_q     <= S_STOP;
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= OP_STOP;
                cmd_nack_q  <= 1'b0;
              end
            end
          end else if (bus.rsp_valid) begin
            wait_q      <= 1'b0;
            state_q     <= state_d;
            cmd_valid_q <= issue_d;
            cmd_op_q    <= op_d;
            cmd_wdata_q <= wdata_d;
            cmd_nack_q  <= nack_d;
            err_acc_q   <= err_d;
            cnt_q       <= cnt_d;
            if (state_q == S_RDATA) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= bus.rsp_rdata;
            end
            if (state_q == S_STOP) begin
              done_q <= 1'b1;
              err_q  <= err_acc_q;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = (state_q == S_WDATA) && !wait_q && cmd_valid_q && bus.cmd_ready;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_wdata = cmd_wdata_q;
  assign bus.cmd_nack  = cmd_nack_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/i2c_txn_ctrl.md
# i2c_txn_ctrl

Transaction sequencer for the Avalon I2C slave peripheral. Accepts register-oriented read/write requests (7-bit device address, 8-bit register address, N data bytes). Breaks each request into the byte-level START/WRITE/READ/STOP command stream consumed by the I2C byte engine. Collects ACK/NACK status and returns read data. Single master only, one transaction in flight.

## Interface
- LEN_W, 4: width of byte-count field; max transfer 2^LEN_W-1 bytes.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_dev  in  7  device address.
- req_reg  in  8  register address.
- req_len  in  LEN_W  data byte count.
- abort  in  1  level request to terminate the current transaction.
- wr_valid / wr_ready  in / out  1 / 1  write-data stream handshake.
- wr_data  in  8  write byte.
- rd_valid  out  1  one-cycle pulse, read byte available; no backpressure.
- rd_data  out  8  read byte.
- done  out  1  one-cycle pulse at transaction end.
- err  out  2  status, valid with done and held until next done: 00 ok, 01 address NACK, 10 data/register NACK, 11 aborted.
- cmd_valid / cmd_ready  out / in  1 / 1  byte-engine command handshake.
- cmd_op  out  2  0 START, 1 WRITE, 2 READ, 3 STOP.
- cmd_wdata  out  8  byte for WRITE.
- cmd_nack  out  1  for READ: 1 = master NACKs this byte.
- rsp_valid  in  1  one-cycle command-complete pulse from engine.
- rsp_nack  in  1  slave NACK on WRITE, sampled with rsp_valid.
- rsp_rdata  in  8  READ result, sampled with rsp_valid.

## Operation
- States: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, DONE. Each non-IDLE/DONE state has an issue phase (cmd_valid high) and a wait phase (waiting for rsp_valid).
- Request fields are latched on req_valid && req_ready.
- Write sequence: START -> WRITE {dev,0} -> WRITE reg -> WRITE data ×len -> STOP.
- Read sequence: START -> WRITE {dev,0} -> WRITE reg -> RSTART (START) -> WRITE {dev,1} -> READ ×len -> STOP. cmd_nack=1 only on the last READ.
- len=0, write or read: pointer-only write, START, addr, reg, STOP; err=00 if acked.
- WDATA issues its command only when wr_valid=1. wr_ready pulses in the cmd handshake cycle, and cmd_wdata=wr_data in that cycle.
- Byte counter decrements per completed data byte; the transition out of WDATA/RDATA is taken when the count reaches 0.
- rsp_nack on ADDR_W/ADDR_R sets err=01; on REG/WDATA sets err=10. In both cases the next state is STOP, skipping remaining bytes.
- abort is sampled at each rsp_valid (and in WDATA issue while starved of wr_valid). It sets err=11 and the next state is STOP. NACK outranks abort when both occur at the same rsp_valid.
- STOP is always issued once START has completed. DONE pulses done for one cycle, then returns to IDLE.
- rsp_valid outside a wait phase is ignored.

## Timing
- Reset values: req_ready=1, wr_ready=0, cmd_valid=0, cmd_op=0, cmd_wdata=0, cmd_nack=0, rd_valid=0, rd_data=0, done=0, err=00.
- cmd_valid asserts the cycle after req handshake. cmd_op, cmd_wdata and cmd_nack are stable while cmd_valid && !cmd_ready. cmd_valid drops the cycle after the handshake.
- rd_valid/rd_data are registered, one cycle after the READ rsp_valid.
- done is asserted one cycle after the STOP rsp_valid, and err is updated in the same cycle as done. req_ready returns the following cycle.
- Minimum spacing: next request is accepted 2 cycles after the STOP response.
- Reset mid-transaction returns to IDLE immediately. Bus recovery is the engine's responsibility.

## Structure
- Shared package i2c_pkg: cmd_op encodings, err codes, state enumeration.
- Single module, no sub-module. Byte counter and field latches are inline.

## Test plan
- Write dev=0x50 reg=0x10 len=2 data 0xA5,0x3C, all ACK -> cmd sequence START, W 0xA0, W 0x10, W 0xA5, W 0x3C, STOP; done with err=00; wr_ready pulses exactly 2 times.
- Read dev=0x50 reg=0x20 len=3, engine returns 0x11,0x22,0x33 -> START, W 0xA0, W 0x20, START, W 0xA1, READ×3 with cmd_nack=0,0,1, STOP; rd_valid pulses 0x11,0x22,0x33; err=00.
- Address NACK on W 0xA0 -> next command STOP; no data commands; err=01.
- Data NACK on first of 4 write bytes -> STOP follows; wr_ready pulsed once; err=10.
- abort asserted during second READ of len=4, with cmd_ready held low 3 cycles on each command -> commands stay stable while stalled; STOP follows the second READ response; err=11.
- Read len=0 plus spurious rsp_valid while in IDLE -> START, W addr, W reg, STOP only; spurious pulse has no effect; err=00.
